// File: rtl/spi_master_mx_if.sv
// spi_master_mx_if -- native picorv32 memory-bus slice seen by spi_master_mx.
//   enable     : address-decoder select for the block
//   mem_valid  : bus request
//   mem_ready  : registered one-cycle acknowledge
//   mem_instr  : instruction fetch flag (not used by the block)
//   mem_wstrb  : byte write strobes, 0 = read
//   mem_wdata  : write data
//   mem_addr   : byte address, only [3:2] decoded
//   mem_rdata  : read data, 0 when enable=0
// master drives requests (CPU side), slave answers (spi_master_mx).
interface spi_master_mx_if;
  logic        enable;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_instr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;

  modport master (
    output enable, mem_valid, mem_instr, mem_wstrb, mem_wdata, mem_addr,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  enable, mem_valid, mem_instr, mem_wstrb, mem_wdata, mem_addr,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/spi_master_mx.sv
// spi_master_mx -- SPI master on the picorv32 native bus.
// 1-4 byte MSB-first transfers, all four SPI modes, programmable SCK rate
// (half period = DIV+1 clk), up to four chip selects, sticky done interrupt.
// Ports:
//   clk, resetn : system clock, synchronous active-low reset
//   bus         : spi_master_mx_if.slave register interface
//   spi_cs_n    : active-low chip selects (NUM_CS wide)
//   spi_ck      : SPI clock
//   spi_mosi    : serial out
//   spi_miso    : serial in, sampled directly
//   irq         : done & irq_en, level
//
// state | meaning
// IDLE  | waiting for a start write, registers writable
// SETUP | CS asserted, SCK at idle level, first bit presented (cpha=0)
// LEAD  | SCK at active level; sample (cpha=0) or drive (cpha=1)
// TRAIL | SCK back to idle; shift, and sample (cpha=1) or drive next (cpha=0)
// HOLD  | CS hold time after the last bit
module spi_master_mx #(
  parameter int         NUM_CS  = 1,
  parameter logic [7:0] DIV_RST = 8'd3
) (
  input  logic              clk,
  input  logic              resetn,
  spi_master_mx_if.slave    bus,
  output logic [NUM_CS-1:0] spi_cs_n,
  output logic              spi_ck,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic              irq
);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_LEAD, S_TRAIL, S_HOLD} state_t;

  state_t              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [4:0]          bit_q, bit_d;
  logic [31:0]         shift_q, shift_d, rx_q, rx_d, data_q, data_d;
  logic [7:0]          div_q, div_d;
  logic [1:0]          nbytes_q, nbytes_d, sel_q, sel_d;
  logic                cs_assert_q, cs_assert_d, keep_q, keep_d;
  logic                cpol_q, cpol_d, cpha_q, cpha_d, irq_en_q, irq_en_d;
  logic                done_q, done_d, ready_q, ready_d;
  logic [NUM_CS-1:0]   cs_n_q, cs_n_d;
  logic                ck_q, ck_d, mosi_q, mosi_d;
  logic                wr_acc, tc, go_lead, go_trail, busy;
  logic [31:0]         ctrl_rd, rdata;
  logic [31:0]         wd;

  // Selected line takes 'level', every other line idles high; a sel beyond
  // NUM_CS matches nothing so no CS asserts.
  function automatic logic [NUM_CS-1:0] cs_vec(input logic [1:0] sel, input logic level);
    cs_vec = '1;
    for (int i = 0; i < NUM_CS; i++)
      if (sel == i[1:0]) cs_vec[i] = level;
  endfunction

  assign wd   = bus.mem_wdata;
  assign busy = (state_q != S_IDLE);
  assign tc   = (cnt_q == 8'd0);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      rx_q        <= '0;
      data_q      <= '0;
      div_q       <= DIV_RST;
      nbytes_q    <= '0;
      sel_q       <= '0;
      cs_assert_q <= 1'b0;
      keep_q      <= 1'b0;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      irq_en_q    <= 1'b0;
      done_q      <= 1'b0;
      ready_q     <= 1'b0;
      cs_n_q      <= '1;
      ck_q        <= 1'b0;
      mosi_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      rx_q        <= rx_d;
      data_q      <= data_d;
      div_q       <= div_d;
      nbytes_q    <= nbytes_d;
      sel_q       <= sel_d;
      cs_assert_q <= cs_assert_d;
      keep_q      <= keep_d;
      cpol_q      <= cpol_d;
      cpha_q      <= cpha_d;
      irq_en_q    <= irq_en_d;
      done_q      <= done_d;
      ready_q     <= ready_d;
      cs_n_q      <= cs_n_d;
      ck_q        <= ck_d;
      mosi_q      <= mosi_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    rx_d        = rx_q;
    data_d      = data_q;
    div_d       = div_q;
    nbytes_d    = nbytes_q;
    sel_d       = sel_q;
    cs_assert_d = cs_assert_q;
    keep_d      = keep_q;
    cpol_d      = cpol_q;
    cpha_d      = cpha_q;
    irq_en_d    = irq_en_q;
    done_d      = done_q;
    cs_n_d      = cs_n_q;
    ck_d        = ck_q;
    mosi_d      = mosi_q;
    go_lead     = 1'b0;
    go_trail    = 1'b0;
    // Request is acted on in the same edge that raises the acknowledge.
    ready_d     = bus.mem_valid & bus.enable & ~ready_q;
    wr_acc      = ready_d & (bus.mem_wstrb == 4'hF);

    unique case (state_q)
      S_IDLE: begin
        if (wr_acc) begin
          unique case (bus.mem_addr[3:2])
            2'd0: data_d = wd;
            2'd1: begin
              nbytes_d    = wd[1:0];
              sel_d       = wd[3:2];
              cs_assert_d = wd[8];
              keep_d      = wd[9];
              cpol_d      = wd[12];
              cpha_d      = wd[13];
              irq_en_d    = wd[14];
              done_d      = 1'b0;
              ck_d        = wd[12];
              cs_n_d      = cs_vec(wd[3:2], ~wd[8]);
              if (wd[31]) begin
                state_d = S_SETUP;
                cnt_d   = div_q;
                bit_d   = {wd[1:0], 3'b111};
                shift_d = data_q;
                rx_d    = '0;
                cs_n_d  = cs_vec(wd[3:2], 1'b0);
                if (!wd[13]) mosi_d = data_q[31];
              end
            end
            2'd2: begin
            end
            2'd3: div_d = wd[7:0];
          endcase
        end
      end
      S_SETUP: begin
        if (tc) go_lead = 1'b1;
        else    cnt_d = cnt_q - 8'd1;
      end
      S_LEAD: begin
        if (tc) go_trail = 1'b1;
        else    cnt_d = cnt_q - 8'd1;
      end
      S_TRAIL: begin
        if (!tc) begin
          cnt_d = cnt_q - 8'd1;
        end else if (bit_q == 5'd0) begin
          state_d = S_HOLD;
          cnt_d   = div_q;
        end else begin
          bit_d   = bit_q - 5'd1;
          go_lead = 1'b1;
        end
      end
      S_HOLD: begin
        if (tc) begin
          state_d = S_IDLE;
          cs_n_d  = cs_vec(sel_q, ~keep_q);
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Entry actions shared by SETUP->LEAD and TRAIL->LEAD.
    if (go_lead) begin
      state_d = S_LEAD;
      cnt_d   = div_q;
      ck_d    = ~cpol_q;
      if (cpha_q) mosi_d = shift_q[31];
      else        rx_d   = {rx_q[30:0], spi_miso};
    end
    if (go_trail) begin
      state_d = S_TRAIL;
      cnt_d   = div_q;
      ck_d    = cpol_q;
      shift_d = {shift_q[30:0], 1'b0};
      if (cpha_q) rx_d   = {rx_q[30:0], spi_miso};
      else        mosi_d = shift_q[30];
    end
  end

  assign ctrl_rd = {busy, done_q, 15'd0, irq_en_q, cpha_q, cpol_q, 2'd0,
                    keep_q, ~&cs_n_q, 4'd0, sel_q, nbytes_q};

  always_comb begin
    rdata = '0;
    if (bus.enable) begin
      unique case (bus.mem_addr[3:2])
        2'd0: rdata = data_q;
        2'd1: rdata = ctrl_rd;
        2'd2: rdata = rx_q;
        2'd3: rdata = {24'd0, div_q};
      endcase
    end
  end

  assign bus.mem_rdata = rdata;
  assign bus.mem_ready = ready_q;
  assign spi_cs_n      = cs_n_q;
  assign spi_ck        = ck_q;
  assign spi_mosi      = mosi_q;
  assign irq           = done_q & irq_en_q;

  logic unused_bus;
  assign unused_bus = ^{bus.mem_instr, bus.mem_addr[31:4], bus.mem_addr[1:0]};

endmodule
